multicycle_seq: RTL and testbench

MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

---
 rtl/multicycle_seq.sv | 174 +++++++++++++++++
 tb/tb_multicycle_seq.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_seq.sv
`default_nettype none
//==============================================================================
// Module   : multicycle_seq
// Brief    : Multicycle instruction sequencer (FETCH/DECODE/EXEC/MEM/WB/HALT)
//            with a per-transaction memory wait timeout. Define SEQ_PERF_CNT_EN
//            to add the cycle_cnt / instret_cnt performance counters.
// Revision : 1.0 - initial release
//==============================================================================
module multicycle_seq #(
    parameter int unsigned WAIT_MAX = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dec_regwr,
    input  logic        dec_memwr,
    input  logic        dec_memtoreg,
    input  logic        dec_branch,
    input  logic        dec_jump,
    input  logic        dec_illegal,
    input  logic        branch_taken,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_sel,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_load,
    output logic        pc_sel_target,
    output logic        rf_we,
    output logic        halted,
    output logic        bus_err,
    output logic [2:0]  state
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt
`endif
);

    localparam logic [2:0]  c_FETCH    = 3'd0;
    localparam logic [2:0]  c_DECODE   = 3'd1;
    localparam logic [2:0]  c_EXEC     = 3'd2;
    localparam logic [2:0]  c_MEM      = 3'd3;
    localparam logic [2:0]  c_WB       = 3'd4;
    localparam logic [2:0]  c_HALT     = 3'd5;
    localparam logic [15:0] c_WAIT_MAX = 16'(WAIT_MAX);

    logic [2:0]  r_state;
    logic [15:0] r_wait_cnt;
    logic        r_bus_err;

    logic [2:0]  w_state_nxt;
    logic [15:0] w_wait_cnt_nxt;
    logic        w_timeout;
    logic        w_mem_req;
    logic        w_mem_sel;
    logic        w_mem_we;
    logic        w_ir_load;
    logic        w_pc_load;
    logic        w_pc_sel_target;
    logic        w_rf_we;

    always_comb begin
        w_state_nxt     = r_state;
        w_timeout       = 1'b0;
        w_mem_req       = 1'b0;
        w_mem_sel       = 1'b0;
        w_mem_we        = 1'b0;
        w_ir_load       = 1'b0;
        w_pc_load       = 1'b0;
        w_pc_sel_target = 1'b0;
        w_rf_we         = 1'b0;
        case (r_state)
            c_FETCH: begin
                w_mem_req = 1'b1;
                if (mem_ready) begin
                    w_ir_load   = 1'b1;
                    w_state_nxt = c_DECODE;
                end else if (r_wait_cnt == c_WAIT_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_HALT;
                end
            end
            c_DECODE: begin
                w_state_nxt = dec_illegal ? c_HALT : c_EXEC;
            end
            c_EXEC: begin
                w_state_nxt = (dec_memwr | dec_memtoreg) ? c_MEM : c_WB;
            end
            c_MEM: begin
                w_mem_req = 1'b1;
                w_mem_sel = 1'b1;
                w_mem_we  = dec_memwr;
                if (mem_ready) begin
                    w_state_nxt = c_WB;
                end else if (r_wait_cnt == c_WAIT_MAX) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = c_HALT;
                end
            end
            c_WB: begin
                w_pc_load       = 1'b1;
                w_rf_we         = dec_regwr;
                w_pc_sel_target = dec_jump | (dec_branch & branch_taken);
                w_state_nxt     = c_FETCH;
            end
            c_HALT: begin
                w_state_nxt = c_HALT;
            end
            default: begin
                w_state_nxt = c_HALT;
            end
        endcase
    end

    // Counter restarts whenever a new request phase is entered
    always_comb begin
        w_wait_cnt_nxt = r_wait_cnt;
        if ((w_state_nxt != r_state) && ((w_state_nxt == c_FETCH) || (w_state_nxt == c_MEM))) begin
            w_wait_cnt_nxt = 16'd0;
        end else if (w_mem_req && !mem_ready) begin
            w_wait_cnt_nxt = r_wait_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_FETCH;
            r_wait_cnt <= 16'd0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            if (w_timeout) begin
                r_bus_err <= 1'b1;
            end
        end
    end

    // Reset forces every output low in the same cycle, abandoning any request
    assign mem_req       = w_mem_req & ~rst;
    assign mem_sel       = w_mem_sel & ~rst;
    assign mem_we        = w_mem_we & ~rst;
    assign ir_load       = w_ir_load & ~rst;
    assign pc_load       = w_pc_load & ~rst;
    assign pc_sel_target = w_pc_sel_target & ~rst;
    assign rf_we         = w_rf_we & ~rst;
    assign halted        = (r_state == c_HALT) & ~rst;
    assign bus_err       = r_bus_err & ~rst;
    assign state         = rst ? 3'd0 : r_state;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_state != c_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if (r_state == c_WB) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = rst ? 32'd0 : r_cycle_cnt;
    assign instret_cnt = rst ? 32'd0 : r_instret_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_multicycle_seq.sv
`default_nettype none
//==============================================================================
// Module   : tb_multicycle_seq
// Brief    : Self-checking bench for multicycle_seq: transaction-level model,
//            randomized instruction mix and memory latencies, directed cases.
// Revision : 1.0 - initial release
//==============================================================================
module tb_multicycle_seq;

    localparam int WM = 4;

    logic clk = 1'b0;
    logic rst;
    logic dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump, dec_illegal;
    logic branch_taken, mem_ready;
    logic mem_req, mem_sel, mem_we, ir_load, pc_load, pc_sel_target, rf_we;
    logic halted, bus_err;
    logic [2:0] state;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt, instret_cnt;
`endif

    multicycle_seq #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst(rst),
        .dec_regwr(dec_regwr), .dec_memwr(dec_memwr), .dec_memtoreg(dec_memtoreg),
        .dec_branch(dec_branch), .dec_jump(dec_jump), .dec_illegal(dec_illegal),
        .branch_taken(branch_taken), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_sel(mem_sel), .mem_we(mem_we),
        .ir_load(ir_load), .pc_load(pc_load), .pc_sel_target(pc_sel_target),
        .rf_we(rf_we), .halted(halted), .bus_err(bus_err), .state(state)
`ifdef SEQ_PERF_CNT_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Expected-output vector layout: {state[2:0], req, sel, we, ir, pl, ps, rw, hl, be}
    logic [11:0] exp_vec   = 12'd0;
    logic        exp_valid = 1'b0;
    logic [11:0] act_vec;
    logic [11:0] log_q[$];
    int          n_tests = 0;
    int          n_fail  = 0;

    string       lit_nm[64];
    logic [31:0] lit_a[64];
    logic [31:0] lit_e[64];
    int          lit_seq  = 0;
    int          lit_done = 0;

    logic m_bus_err = 1'b0;
    logic ready_hi  = 1'b0;

    assign act_vec = {state, mem_req, mem_sel, mem_we, ir_load, pc_load,
                      pc_sel_target, rf_we, halted, bus_err};

    always @(negedge clk) begin
        if (exp_valid) begin
            n_tests++;
            if (act_vec !== exp_vec) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t actual=%b required=%b", $time, act_vec, exp_vec);
            end
            log_q.push_back(act_vec);
        end
        while (lit_done < lit_seq) begin
            n_tests++;
            if (lit_a[lit_done] !== lit_e[lit_done]) begin
                n_fail++;
                $display("FAIL %s actual=%0d required=%0d", lit_nm[lit_done], lit_a[lit_done], lit_e[lit_done]);
            end
            lit_done++;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [11:0] pk(input logic [2:0] st, input logic rq, input logic sl,
                                       input logic we, input logic ir, input logic pl,
                                       input logic ps, input logic rw, input logic hl,
                                       input logic be);
        return {st, rq, sl, we, ir, pl, ps, rw, hl, be};
    endfunction

    function automatic logic noise();
        return ready_hi ? 1'b1 : 1'($urandom);
    endfunction

    function automatic int st_trace(input int from);
        int t = 0;
        for (int i = from; i < log_q.size(); i++) t = t * 10 + int'(log_q[i][11:9]) + 1;
        return t;
    endfunction

    function automatic logic [31:0] bit_trace(input int from, input int pos);
        logic [31:0] t = 32'd0;
        for (int i = from; i < log_q.size(); i++) t = {t[30:0], log_q[i][pos]};
        return t;
    endfunction

    function automatic int rand_dly();
        int r = int'($urandom_range(0, 15));
        if (r < 13) return r % 5;
        if (r < 15) return WM;
        return WM + 2;
    endfunction

    task automatic lit(input string nm, input logic [31:0] a, input logic [31:0] e);
        lit_nm[lit_seq] = nm;
        lit_a[lit_seq]  = a;
        lit_e[lit_seq]  = e;
        lit_seq++;
    endtask

    // One clock cycle: drive mem_ready, publish the expected outputs
    task automatic cyc(input logic rdy, input logic [11:0] e);
        mem_ready = rdy;
        exp_vec   = e;
        exp_valid = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n, input logic rdy);
        rst = 1'b1;
        for (int i = 0; i < n; i++) cyc(rdy, 12'd0);
        rst = 1'b0;
        m_bus_err = 1'b0;
    endtask

    task automatic halt_cycles(input int n);
        for (int i = 0; i < n; i++) cyc(noise(), pk(3'd5, 0, 0, 0, 0, 0, 0, 0, 1, m_bus_err));
    endtask

    // A memory phase lasts until ready (at wait index dly) or WAIT_MAX+1 idle cycles
    task automatic mem_phase(input logic [2:0] st, input logic sl, input logic we,
                             input int dly, output logic ok);
        logic rdy;
        ok = 1'b0;
        for (int k = 0; k <= WM; k++) begin
            if (!ok) begin
                rdy = (k == dly);
                cyc(rdy, pk(st, 1, sl, we, (st == 3'd0) & rdy, 0, 0, 0, 0, 0));
                ok = rdy;
            end
        end
        if (!ok) m_bus_err = 1'b1;
    endtask

    task automatic run_instr(input logic rw, input logic mw, input logic mr, input logic br,
                             input logic jp, input logic il, input logic tk,
                             input int fd, input int md, output logic hlt);
        logic ok;
        hlt = 1'b1;
        {dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump, dec_illegal} = 6'($urandom);
        branch_taken = 1'($urandom);
        mem_phase(3'd0, 1'b0, 1'b0, fd, ok);
        if (!ok) return;
        {dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump, dec_illegal} = {rw, mw, mr, br, jp, il};
        branch_taken = tk;
        cyc(noise(), pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (il) return;
        cyc(noise(), pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        if (mw | mr) begin
            mem_phase(3'd3, 1'b1, mw, md, ok);
            if (!ok) return;
        end
        cyc(noise(), pk(3'd4, 0, 0, 0, 0, 1, jp | (br & tk), rw, 0, 0));
        hlt = 1'b0;
    endtask

    initial begin
        int   s;
        logic h;
        rst = 1'b1;
        {dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump, dec_illegal} = 6'd0;
        branch_taken = 1'b0;
        mem_ready    = 1'b0;
        @(posedge clk);
        #1;
        do_reset(2, 1'b1);

`ifdef SEQ_PERF_CNT_EN
        ready_hi = 1'b1;
        for (int i = 0; i < 10; i++) run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, h);
        lit("perf_cycle_cnt", cycle_cnt, 32'd40);
        lit("perf_instret_cnt", instret_cnt, 32'd10);
        dut.r_cycle_cnt   = 32'hFFFF_FFFF;
        dut.r_instret_cnt = 32'hFFFF_FFFF;
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, h);
        lit("perf_cycle_wrap", cycle_cnt, 32'd3);
        lit("perf_instret_wrap", instret_cnt, 32'd0);
        ready_hi = 1'b0;
`endif

        // add with mem_ready tied high
        ready_hi = 1'b1;
        s = log_q.size();
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, h);
        lit("add_states", st_trace(s), 1235);
        lit("add_rf_we", bit_trace(s, 2), 32'b0001);
        lit("add_pc_sel", bit_trace(s, 3), 32'b0000);
        ready_hi = 1'b0;

        // load, data ready after 3 wait cycles
        s = log_q.size();
        run_instr(1, 0, 1, 0, 0, 0, 0, 0, 3, h);
        lit("load_states", st_trace(s), 12344445);
        lit("load_mem_req", bit_trace(s, 8), 32'b10011110);
        lit("load_mem_sel", bit_trace(s, 7), 32'b00011110);
        lit("load_mem_we", bit_trace(s, 6), 32'b0);
        lit("load_rf_we", bit_trace(s, 2), 32'b00000001);

        // beq taken / not taken
        s = log_q.size();
        run_instr(0, 0, 0, 1, 0, 0, 1, 0, 0, h);
        lit("beq_t_pc_load", bit_trace(s, 4), 32'b0001);
        lit("beq_t_pc_sel", bit_trace(s, 3), 32'b0001);
        lit("beq_t_rf_we", bit_trace(s, 2), 32'b0000);
        s = log_q.size();
        run_instr(0, 0, 0, 1, 0, 0, 0, 0, 0, h);
        lit("beq_nt_pc_sel", bit_trace(s, 3), 32'b0000);

        // randomized instruction mix with random latencies (timeouts included)
        for (int i = 0; i < 60; i++) begin
            int   t, fd, md;
            logic rw, mw, mr, br, jp, il, tk;
            t  = int'($urandom_range(0, 3));
            rw = 1'($urandom);
            mw = (t == 2);
            mr = (t == 1);
            br = (t == 3) & 1'($urandom);
            jp = (t == 3) & ~br;
            il = ($urandom_range(0, 19) == 0);
            tk = 1'($urandom);
            fd = rand_dly();
            md = rand_dly();
            run_instr(rw, mw, mr, br, jp, il, tk, fd, md, h);
            if (h) begin
                halt_cycles(2);
                do_reset(1, 1'($urandom));
            end
        end

        // reset in the middle of a fetch, with ready arriving during reset
        s = log_q.size();
        cyc(1'b0, pk(3'd0, 1, 0, 0, 0, 0, 0, 0, 0, 0));
        do_reset(1, 1'b1);
        lit("rst_fetch_ir_load", bit_trace(s, 5), 32'b0);

        // reset in the middle of a load's MEM phase
        s = log_q.size();
        {dec_regwr, dec_memwr, dec_memtoreg, dec_branch, dec_jump, dec_illegal} = 6'b101000;
        cyc(1'b1, pk(3'd0, 1, 0, 0, 1, 0, 0, 0, 0, 0));
        cyc(1'b0, pk(3'd1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, pk(3'd2, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        cyc(1'b0, pk(3'd3, 1, 1, 0, 0, 0, 0, 0, 0, 0));
        do_reset(1, 1'b1);
        run_instr(1, 0, 0, 0, 0, 0, 0, 0, 0, h);
        lit("rst_mem_rf_we", bit_trace(s, 2), 32'b000000001);

        // illegal instruction halts without bus error, reset recovers
        s = log_q.size();
        run_instr(1, 0, 0, 0, 0, 1, 0, 0, 0, h);
        halt_cycles(3);
        lit("illegal_states", st_trace(s), 12666);
        lit("illegal_bus_err", 32'(bus_err), 32'd0);
        lit("illegal_halted", 32'(halted), 32'd1);
        do_reset(1, 1'b1);
        mem_ready = 1'b0;
        #1;
        lit("post_rst_state", 32'(state), 32'd0);
        lit("post_rst_mem_req", 32'(mem_req), 32'd1);
        lit("post_rst_halted", 32'(halted), 32'd0);

        // fetch never answered: timeout after WAIT_MAX waits, ready later ignored
        s = log_q.size();
        run_instr(1, 0, 0, 0, 0, 0, 0, WM + 5, 0, h);
        ready_hi = 1'b1;
        halt_cycles(3);
        ready_hi = 1'b0;
        lit("timeout_states", st_trace(s), 11111666);
        lit("timeout_bus_err", 32'(bus_err), 32'd1);
        lit("timeout_halted", 32'(halted), 32'd1);

        // store whose data phase times out
        do_reset(1, 1'b0);
        run_instr(0, 1, 0, 0, 0, 0, 0, 1, WM + 3, h);
        halt_cycles(2);
        lit("mem_timeout_bus_err", 32'(bus_err), 32'd1);
        do_reset(1, 1'b0);
        run_instr(1, 0, 0, 0, 0, 0, 0, WM, WM, h);

        exp_valid = 1'b0;
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
